// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: round-robin arbiter for the single write port of the 8x16
// general register file. Requesters use valid/ready. Each accepted request
// becomes one registered write beat on the following cycle.
// Optional feature macro: RF_ARB_LOCK_EN. When it is defined, a requester can
// hold the grant across several transfers by asserting req_lock.
module rf_wr_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic [NREQ-1:0]          req_lock,
  output logic [NREQ-1:0]          req_ready,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic [$clog2(NREQ)-1:0]  gnt_id
);

  localparam int GW = $clog2(NREQ);

  logic [GW-1:0] ptr;
  logic [GW-1:0] win;
  logic          found;
  logic          xfer;
  logic          locked;
  logic [GW-1:0] lock_own;

`ifdef RF_ARB_LOCK_EN
  // The grant owner records whether it asked to keep the port on its last transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked   <= 1'b0;
      lock_own <= '0;
    end else if (xfer) begin
      locked   <= req_lock[win];
      lock_own <= win;
    end
  end
`else
  // No locking in this build. req_lock stays on the port so the interface does not change.
  logic unused_lock;
  assign locked      = 1'b0;
  assign lock_own    = '0;
  assign unused_lock = ^req_lock;
`endif

  // Rotating priority search. It starts just after the last winner and wraps around.
  always_comb begin
    int            idx;
    logic [GW-1:0] cand;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = GW'(idx);
      if (!found && req_valid[cand] && (!locked || cand == lock_own)) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // One-hot accept. It is forced low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (found && !rst) req_ready = NREQ'(1) << win;
  end

  assign xfer = found & ~rst;

  // Register the winning beat. With no transfer, wr_en drops and the other write fields hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      gnt_id  <= '0;
      ptr     <= GW'(NREQ - 1);
    end else if (xfer) begin
      wr_en   <= 1'b1;
      wr_addr <= req_addr[int'(win)*ADDR_W +: ADDR_W];
      wr_data <= req_data[int'(win)*DATA_W +: DATA_W];
      gnt_id  <= win;
      ptr     <= win;
    end else begin
      wr_en   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter with NREQ=4. Inputs change 1ns after the
// rising edge. req_ready is sampled 1ns after that. wr_* is sampled 1ns after
// the next rising edge.
module tb_rf_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW = 16;
  localparam int AW = 3;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_lock;
  logic [NREQ-1:0]   req_ready;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [1:0]        gnt_id;

  int checks;
  int failures;
  logic [DW-1:0] rf [8];

  rf_wr_arbiter #(.NREQ(NREQ), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_lock(req_lock), .req_ready(req_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .gnt_id(gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model, written from the arbiter's write port.
  always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic l);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = d;
    req_lock[i]           = l;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i), DW'(16'h1000 + i), 1'b0);
    next_cycle();
    next_cycle();
    checks++;
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++;
    if (wr_en !== 1'b0 || wr_addr !== 3'd0 || wr_data !== 16'd0 || gnt_id !== 2'd0) begin
      failures++; $display("FAIL reset_outputs got en=%b a=%0d d=%h g=%0d exp 0", wr_en, wr_addr, wr_data, gnt_id);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL first_grant_ready got=%b exp=0001", req_ready); end
    req_valid = '0;
    req_valid[0] = 1'b1;
    next_cycle();
    req_valid = '0;
    checks++;
    if (wr_en !== 1'b1 || gnt_id !== 2'd0 || wr_data !== 16'h1000) begin
      failures++; $display("FAIL first_grant_write got en=%b g=%0d d=%h exp en=1 g=0 d=1000", wr_en, gnt_id, wr_data);
    end
  endtask

  task automatic test_single_write();
    set_req(1, 1'b1, 3'd3, 16'hBEEF, 1'b0);
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL single_ready got=%b exp=0010", req_ready); end
    next_cycle();
    req_valid = '0;
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 3'd3 || wr_data !== 16'hBEEF || gnt_id !== 2'd1) begin
      failures++; $display("FAIL single_write got en=%b a=%0d d=%h g=%0d exp 1/3/beef/1", wr_en, wr_addr, wr_data, gnt_id);
    end
    next_cycle();
    checks++;
    if (wr_en !== 1'b0 || wr_addr !== 3'd3 || wr_data !== 16'hBEEF || gnt_id !== 2'd1) begin
      failures++; $display("FAIL idle_hold got en=%b a=%0d d=%h g=%0d exp 0/3/beef/1", wr_en, wr_addr, wr_data, gnt_id);
    end
  endtask

  task automatic test_round_robin();
    int ens;
    // Park the pointer on requester 3 so the next rotation starts at 0.
    set_req(3, 1'b1, 3'd7, 16'h0333, 1'b0);
    next_cycle();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i), DW'(16'h2000 + i), 1'b0);
    ens = 0;
    for (int c = 0; c < 8; c++) begin
      logic [3:0] exp_rdy;
      exp_rdy = 4'b0001 << (c % 4);
      #1;
      checks++;
      if (req_ready !== exp_rdy) begin failures++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
      next_cycle();
      if (wr_en === 1'b1) ens++;
      checks++;
      if (gnt_id !== 2'(c % 4) || wr_data !== DW'(16'h2000 + c % 4)) begin
        failures++; $display("FAIL rr_grant c=%0d got g=%0d d=%h exp g=%0d", c, gnt_id, wr_data, c % 4);
      end
    end
    req_valid = '0;
    checks++;
    if (ens != 8) begin failures++; $display("FAIL rr_wr_en_count got=%0d exp=8", ens); end
    next_cycle();
  endtask

  task automatic test_collision();
    // Make requester 0 the last winner.
    set_req(0, 1'b1, 3'd1, 16'h0001, 1'b0);
    next_cycle();
    set_req(0, 1'b1, 3'd5, 16'd10, 1'b0);
    set_req(2, 1'b1, 3'd5, 16'd20, 1'b0);
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin failures++; $display("FAIL coll_first_ready got=%b exp=0100", req_ready); end
    next_cycle();
    req_valid[2] = 1'b0;
    checks++;
    if (gnt_id !== 2'd2 || wr_data !== 16'd20 || wr_addr !== 3'd5) begin
      failures++; $display("FAIL coll_first_write got g=%0d d=%0d exp g=2 d=20", gnt_id, wr_data);
    end
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL coll_second_ready got=%b exp=0001", req_ready); end
    next_cycle();
    req_valid = '0;
    checks++;
    if (gnt_id !== 2'd0 || wr_data !== 16'd10) begin
      failures++; $display("FAIL coll_second_write got g=%0d d=%0d exp g=0 d=10", gnt_id, wr_data);
    end
    next_cycle();
    checks++;
    if (rf[5] !== 16'd10) begin failures++; $display("FAIL coll_final_r5 got=%0d exp=10", rf[5]); end
  endtask

  task automatic test_lock();
    // The pointer is at 0, so requester 3 beats requester 0 here.
    set_req(0, 1'b1, 3'd2, 16'hAAAA, 1'b0);
    set_req(3, 1'b1, 3'd4, 16'h3001, 1'b1);
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin failures++; $display("FAIL lock_first_ready got=%b exp=1000", req_ready); end
    next_cycle();
`ifdef RF_ARB_LOCK_EN
    req_valid[3] = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL lock_starve_idle got=%b exp=0000", req_ready); end
    next_cycle();
    set_req(3, 1'b1, 3'd4, 16'h3002, 1'b1);
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin failures++; $display("FAIL lock_hold_ready got=%b exp=1000", req_ready); end
    next_cycle();
    set_req(3, 1'b1, 3'd4, 16'h3003, 1'b0);
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin failures++; $display("FAIL lock_release_ready got=%b exp=1000", req_ready); end
    next_cycle();
    req_valid[3] = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL lock_after_ready got=%b exp=0001", req_ready); end
`else
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL nolock_next_ready got=%b exp=0001", req_ready); end
`endif
    next_cycle();
    req_valid = '0;
    req_lock  = '0;
    checks++;
    if (wr_en !== 1'b1 || gnt_id !== 2'd0 || wr_data !== 16'hAAAA) begin
      failures++; $display("FAIL lock_req0_write got en=%b g=%0d d=%h exp 1/0/aaaa", wr_en, gnt_id, wr_data);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_stream();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i), DW'(16'h4000 + i), 1'b0);
    next_cycle();
    next_cycle();
    checks++;
    if (wr_en !== 1'b1) begin failures++; $display("FAIL midrst_streaming got en=%b exp=1", wr_en); end
    rst = 1'b1;
    #1;
    checks++;
    if (wr_en !== 1'b0 || req_ready !== 4'b0000) begin
      failures++; $display("FAIL midrst_async got en=%b rdy=%b exp 0/0000", wr_en, req_ready);
    end
    next_cycle();
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL midrst_restart_ready got=%b exp=0001", req_ready); end
    next_cycle();
    checks++;
    if (wr_en !== 1'b1 || gnt_id !== 2'd0 || wr_data !== 16'h4000) begin
      failures++; $display("FAIL midrst_restart_write got en=%b g=%0d d=%h exp 1/0/4000", wr_en, gnt_id, wr_data);
    end
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL midrst_rotate got=%b exp=0010", req_ready); end
    req_valid = '0;
    next_cycle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 8; i++) rf[i] = '0;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    req_lock = '0;
    rst = 1'b1;
    #1;
    test_reset();
    test_single_write();
    test_round_robin();
    test_collision();
    test_lock();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
